// File: rtl/aes_128_sched.sv
// aes_128_sched: round-robin front end that shares one AES-128 core between two requesters.
// It also streams round-key words into the core. Define AES_SCHED_STATS_EN to add the saturating stats counters.
//
// state | meaning
// IDLE  | core empty; a key load wins, otherwise a block is granted round-robin
// WAIT  | one block in the core, watchdog counting
// KEYLD | streaming KEY_WORDS round-key words into the core
module aes_128_sched #(
  parameter int KEY_WORDS      = 22,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_W           = 7
) (
  input  logic         clk,
  input  logic         kill,
  input  logic         req0_valid,
  input  logic [127:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [127:0] req1_data,
  output logic         req1_ready,
  input  logic         key_valid,
  input  logic [63:0]  key_word,
  output logic         key_ready,
  output logic         core_in_en,
  output logic [127:0] core_in_data,
  output logic         core_en_wr,
  output logic [63:0]  core_key_wr,
  input  logic         core_out_en,
  input  logic [127:0] core_out_data,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [127:0] rsp_data,
  output logic         busy,
  output logic         timeout_err
`ifdef AES_SCHED_STATS_EN
  ,
  output logic [15:0]  blk_count,
  output logic [7:0]   to_count,
  output logic [7:0]   key_count
`endif
);

  localparam int KW_W = $clog2(KEY_WORDS + 1);

  typedef enum logic [1:0] {IDLE, WAIT, KEYLD} state_t;

  state_t          state;
  state_t          state_nxt;
  logic            rr_ptr;
  logic            grant_id;
  logic [127:0]    grant_data;
  logic            blk_hs;
  logic            key_hs;
  logic            key_last;
  logic            wd_exp;
  logic            rsp_set;
  logic            to_set;
  logic [KW_W-1:0] kw_cnt;
  logic [TO_W-1:0] wd_cnt;

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    grant_id = req1_valid;
    if (req0_valid && req1_valid) grant_id = rr_ptr;
  end

  assign grant_data = grant_id ? req1_data : req0_data;

  // Holding off grants while the last key word is written gives core_in_en two cycles of spacing.
  assign blk_hs     = (state == IDLE) && !key_valid && !core_en_wr &&
                      (req0_valid || req1_valid);
  assign req0_ready = blk_hs && !grant_id;
  assign req1_ready = blk_hs && grant_id;
  assign key_ready  = (state == KEYLD);
  assign key_hs     = key_valid && key_ready;
  assign key_last   = key_hs && (kw_cnt == KW_W'(KEY_WORDS - 1));
  assign wd_exp     = (wd_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign rsp_set    = (state == WAIT) && core_out_en;
  assign to_set     = (state == WAIT) && !core_out_en && wd_exp;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge kill) begin
    if (kill) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (key_valid)   state_nxt = KEYLD;
        else if (blk_hs) state_nxt = WAIT;
      end
      WAIT: begin
        if (core_out_en || wd_exp) state_nxt = IDLE;
      end
      KEYLD: begin
        if (key_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge kill) begin
    if (kill) begin
      rr_ptr       <= 1'b0;
      core_in_en   <= 1'b0;
      core_in_data <= '0;
      rsp_id       <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      timeout_err  <= 1'b0;
      wd_cnt       <= '0;
    end else begin
      core_in_en  <= blk_hs;
      rsp_valid   <= rsp_set;
      timeout_err <= to_set;
      if (blk_hs) begin
        core_in_data <= grant_data;
        rsp_id       <= grant_id;
        rr_ptr       <= ~grant_id;
      end else if ((state == WAIT) && (state_nxt == IDLE)) begin
        core_in_data <= '0;
      end
      if (rsp_set) rsp_data <= core_out_data;
      // Counter is 0 in the core_in_en cycle, so expiry lands TIMEOUT_CYCLES after it.
      if ((state == WAIT) && (state_nxt == WAIT)) wd_cnt <= wd_cnt + 1'b1;
      else                                        wd_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge kill) begin
    if (kill) begin
      core_en_wr  <= 1'b0;
      core_key_wr <= '0;
      kw_cnt      <= '0;
    end else begin
      core_en_wr  <= key_hs;
      core_key_wr <= key_hs ? key_word : 64'h0;
      if (key_last)    kw_cnt <= '0;
      else if (key_hs) kw_cnt <= kw_cnt + 1'b1;
    end
  end

`ifdef AES_SCHED_STATS_EN
  always_ff @(posedge clk or posedge kill) begin
    if (kill) begin
      blk_count <= '0;
      to_count  <= '0;
      key_count <= '0;
    end else begin
      if (rsp_set && (blk_count != 16'hffff)) blk_count <= blk_count + 1'b1;
      if (to_set && (to_count != 8'hff))      to_count  <= to_count + 1'b1;
      if (key_last && (key_count != 8'hff))   key_count <= key_count + 1'b1;
    end
  end
`endif

endmodule
